// File: rtl/fplib_pkg.sv
// Shared fixed-point helpers: stream-to-array FSM state and
// requantization width / shift / rounding constant functions.
package fplib_pkg;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } s2a_state_e;

    function automatic int rq_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Intermediate width with one guard bit for the rounding add.
    function automatic int rq_width(input int iwi, input int qwi,
                                    input int iwo, input int qwo);
        return rq_max(iwi, iwo) + rq_max(qwi, qwo) + 1;
    endfunction

    // Positive: left shift amount; negative: right shift amount.
    function automatic int rq_shift(input int qwi, input int qwo);
        return qwo - qwi;
    endfunction

    // Half-LSB constant added before a right shift by d.
    function automatic int rq_round(input int d);
        return (d > 0) ? (1 << (d - 1)) : 0;
    endfunction

endpackage

// File: rtl/fp_requant.sv
// Combinational signed fixed-point requantizer (Q IW_I.QW_I -> Q IW_O.QW_O)
// with saturation; rounds half-up when FPLIB_ROUND_EN is defined, else floors.
// Ports: din_i input scalar, val_o requantized value, sat_o clamped flag.
module fp_requant
    import fplib_pkg::*;
#(
    parameter int IW_I = 4,
    parameter int QW_I = 4,
    parameter int IW_O = 2,
    parameter int QW_O = 2
) (
    input  logic [IW_I+QW_I-1:0] din_i,
    output logic [IW_O+QW_O-1:0] val_o,
    output logic                 sat_o
);

    localparam int WO = IW_O + QW_O;
    localparam int W  = rq_width(IW_I, QW_I, IW_O, QW_O);
    localparam int SH = rq_shift(QW_I, QW_O);
    localparam int LS = (SH > 0) ? SH : 0;
    localparam int RS = (SH < 0) ? -SH : 0;

    localparam logic signed [W-1:0] MAXV = W'((2 ** (WO - 1)) - 1);
    localparam logic signed [W-1:0] MINV = -MAXV - W'(1);

    logic signed [W-1:0] ext;
    logic signed [W-1:0] rnd;
    logic signed [W-1:0] shf;

    always_comb begin
        ext = W'($signed(din_i));
`ifdef FPLIB_ROUND_EN
        rnd = W'(rq_round(RS));
`else
        rnd = '0;
`endif
        // Only one of LS/RS is non-zero for a given parameter set.
        shf   = ((ext + rnd) <<< LS) >>> RS;
        sat_o = (shf > MAXV) || (shf < MINV);
        if (shf > MAXV) begin
            val_o = MAXV[WO-1:0];
        end else if (shf < MINV) begin
            val_o = MINV[WO-1:0];
        end else begin
            val_o = shf[WO-1:0];
        end
    end

endmodule

// File: rtl/fp_stream2arr.sv
// Collects SIZE requantized scalars into a frame with valid/ready on both
// sides. Rounding selected by FPLIB_ROUND_EN (see fp_requant).
// Ports: clk, rst_n (async low), clr (drop partial frame), din/in_valid/
// in_ready input stream, dout/out_valid/out_ready frame, sat frame flag.
module fp_stream2arr
    import fplib_pkg::*;
#(
    parameter int IW_I = 4,
    parameter int QW_I = 4,
    parameter int IW_O = 2,
    parameter int QW_O = 2,
    parameter int SIZE = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           clr,
    input  logic [IW_I+QW_I-1:0]           din,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic [SIZE-1:0][IW_O+QW_O-1:0] dout,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           sat
);

    localparam int WO   = IW_O + QW_O;
    localparam int IDXW = $clog2(SIZE);
    localparam logic [IDXW-1:0] LAST = IDXW'(SIZE - 1);

    s2a_state_e state_q, state_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [SIZE-1:0][WO-1:0] buf_q, buf_d;
    logic [SIZE-1:0][WO-1:0] dout_q, dout_d;
    logic [SIZE-1:0][WO-1:0] frame_w;
    logic sticky_q, sticky_d;
    logic sat_q, sat_d;
    logic ov_q, ov_d;
    logic [WO-1:0] rq_val;
    logic rq_sat;
    logic out_free;

    fp_requant #(
        .IW_I(IW_I),
        .QW_I(QW_I),
        .IW_O(IW_O),
        .QW_O(QW_O)
    ) u_rq (
        .din_i(din),
        .val_o(rq_val),
        .sat_o(rq_sat)
    );

    assign in_ready  = rst_n && (state_q == FILL);
    assign out_valid = ov_q;
    assign dout      = dout_q;
    assign sat       = sat_q;
    assign out_free  = !ov_q || out_ready;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        buf_d    = buf_q;
        sticky_d = sticky_q;
        dout_d   = dout_q;
        sat_d    = sat_q;
        ov_d     = ov_q;
        frame_w  = buf_q;
        frame_w[idx_q] = rq_val;

        if (ov_q && out_ready) begin
            ov_d = 1'b0;
        end

        if (clr) begin
            state_d  = FILL;
            idx_d    = '0;
            buf_d    = '0;
            sticky_d = 1'b0;
        end else begin
            unique case (state_q)
                FILL: begin
                    if (in_valid) begin
                        buf_d    = frame_w;
                        sticky_d = sticky_q | rq_sat;
                        if (idx_q != LAST) begin
                            idx_d = idx_q + IDXW'(1);
                        end else if (out_free) begin
                            dout_d   = frame_w;
                            sat_d    = sticky_q | rq_sat;
                            ov_d     = 1'b1;
                            idx_d    = '0;
                            sticky_d = 1'b0;
                        end else begin
                            state_d = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (ov_q && out_ready) begin
                        dout_d   = buf_q;
                        sat_d    = sticky_q;
                        ov_d     = 1'b1;
                        idx_d    = '0;
                        sticky_d = 1'b0;
                        state_d  = FILL;
                    end
                end
                default: begin
                    state_d = FILL;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= FILL;
            idx_q    <= '0;
            buf_q    <= '0;
            sticky_q <= 1'b0;
            dout_q   <= '0;
            sat_q    <= 1'b0;
            ov_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            buf_q    <= buf_d;
            sticky_q <= sticky_d;
            dout_q   <= dout_d;
            sat_q    <= sat_d;
            ov_q     <= ov_d;
        end
    end

endmodule

// File: doc/fp_stream2arr.md
FP_STREAM2ARR -- requirements
Module: fp_stream2arr

Interface
REQ-001 SHALL have parameter IW_I, default 4: input integer bits, sign included.
REQ-002 SHALL have parameter QW_I, default 4: input fractional bits.
REQ-003 SHALL have parameter IW_O, default 2: output integer bits, sign included.
REQ-004 SHALL have parameter QW_O, default 2: output fractional bits.
REQ-005 SHALL have parameter SIZE, default 4, minimum 2: elements per output frame.
REQ-006 SHALL have port clk, input, 1 bit: single clock; all state is updated on its rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-008 SHALL have port clr, input, 1 bit: synchronous discard of the partial frame.
REQ-009 SHALL have port din, sfp.in, IW_I+QW_I bits: signed fixed-point input scalar.
REQ-010 SHALL have port in_valid, input, 1 bit: din is valid.
REQ-011 SHALL have port in_ready, output, 1 bit: the block accepts din.
REQ-012 SHALL have port dout, sfp_arr.out, SIZE x (IW_O+QW_O) bits: assembled frame.
REQ-013 SHALL have port out_valid, output, 1 bit: dout holds a complete frame.
REQ-014 SHALL have port out_ready, input, 1 bit: the consumer takes dout.
REQ-015 SHALL have port sat, output, 1 bit: at least one element of the dout frame saturated.

Function
REQ-016 SHALL accept an element only on a cycle with in_valid && in_ready, and SHALL write it to assembly slot idx, idx running 0..SIZE-1.
REQ-017 SHALL requantize each element combinationally before writing it.
- QW_O >= QW_I: left shift by QW_O-QW_I.
- QW_O < QW_I: arithmetic right shift by d = QW_I-QW_O, with rounding per REQ-030.
- Then saturate to [-2^(IW_O+QW_O-1), 2^(IW_O+QW_O-1)-1].
REQ-018 SHALL compute requantization in an intermediate width of max(IW_I,IW_O)+max(QW_I,QW_O)+1 bits so that the rounding add cannot overflow.
REQ-019 SHALL OR each element's saturation event into a per-frame sticky flag.
REQ-020 SHALL implement a state machine with FILL (idx<SIZE) and HOLD (frame complete, output register occupied).
REQ-021 On accepting slot SIZE-1, if the output register is free (!out_valid || out_ready), SHALL copy the frame and flag to dout/sat, set out_valid the next cycle, reset idx to 0 and stay in FILL; otherwise SHALL go to HOLD.
REQ-022 In HOLD, SHALL drive in_ready=0 and SHALL transfer the frame on the first cycle out_valid && out_ready, then return to FILL.
REQ-023 In FILL, SHALL drive in_ready=1; latency from the last element accepted to out_valid SHALL be 1 cycle when unblocked.
REQ-024 SHALL clear out_valid after a handshake (out_valid && out_ready) with no new frame loaded the same cycle.
REQ-025 SHALL hold dout, sat and out_valid stable while out_valid && !out_ready.
REQ-026 clr SHALL zero idx, the sticky flag and the assembly buffer, and return to FILL; an element presented the same cycle SHALL be dropped; dout/out_valid SHALL be unaffected.
REQ-027 clr SHALL take priority over acceptance and over the HOLD transfer.

Reset
REQ-028 On rst_n low, SHALL asynchronously set: state FILL, idx 0, out_valid 0, sat 0, all dout.val elements 0, assembly buffer 0; in_ready SHALL be 0 while rst_n is low.
REQ-029 SHALL ignore a partially assembled frame at reset; after release the first accepted element SHALL land in slot 0.

Configuration
REQ-030 With FPLIB_ROUND_EN defined, SHALL round half-up by adding 2^(d-1) before the shift; without it, SHALL truncate toward -infinity (plain arithmetic shift); saturation SHALL apply in both cases.

Structure
REQ-031 SHALL place the state enum and a requantize width/shift constant function in the shared package fplib_pkg.
REQ-032 SHALL put requantization in sub-module fp_requant (combinational, parameters IW_I/QW_I/IW_O/QW_O, outputs value plus sat bit); the FSM, counter and buffers SHALL reside in fp_stream2arr.

Verification
All scenarios use the defaults.
REQ-033 Bench SHALL cover: din 1.375 (0x16) with FPLIB_ROUND_EN -> element 1.5 (4'b0110); without it -> 1.25 (4'b0101).
REQ-034 Bench SHALL cover: din 3.0 -> 1.75 (4'b0111), sat=1; din -3.0 -> -2.0 (4'b1000); din 1.9375 with rounding -> 1.75, sat=1.
REQ-035 Bench SHALL cover: 4 back-to-back elements with out_ready=1 -> out_valid 1 cycle after the 4th acceptance, in_ready never 0.
REQ-036 Bench SHALL cover: out_ready=0, 8 elements offered -> second frame reaches HOLD, in_ready=0, dout stable; out_ready=1 -> frame 2 appears on the next cycle, in_ready=1.
REQ-037 Bench SHALL cover: clr after 2 elements -> next 4 elements form the frame, with no residue from the discarded ones.
REQ-038 Bench SHALL cover: rst_n asserted mid-frame and with out_valid=1 -> out_valid=0, dout all zero immediately (asynchronously).
